// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: memory request parameters, FSM states
// and access-size helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_READ  = 2'd1,
    MEM_OP_WRITE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  typedef struct packed {
    mem_op_t     op;
    mem_access_t access_size;
    logic        load_unsigned;
  } mem_params_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } lsu_state_t;

  function automatic logic [3:0] size_mask(input mem_access_t sz);
    case (sz)
      MEM_ACCESS_BYTE: size_mask = 4'b0001;
      MEM_ACCESS_HALF: size_mask = 4'b0011;
      default:         size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input mem_access_t sz);
    case (sz)
      MEM_ACCESS_BYTE: size_bytes = 3'd1;
      MEM_ACCESS_HALF: size_bytes = 3'd2;
      default:         size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the load/store unit: byte enables and store data for
// both beats, and merge plus sign/zero extension of load beats.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  mem_access_t access_size,
  input  logic        load_unsigned,
  input  logic        split,
  input  logic [31:0] wdata,
  input  logic [31:0] beat0,
  input  logic [31:0] beat1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata
);

  logic [5:0]  sh0, sh1;
  logic [7:0]  mask8;
  logic [31:0] merged;

  assign sh0    = {1'b0, off, 3'b000};
  // off=0 gives a 32-bit shift, which clears beat-1 data as intended
  assign sh1    = 6'd32 - sh0;
  assign mask8  = {4'b0000, size_mask(access_size)} << off;
  assign be0    = mask8[3:0];
  assign be1    = mask8[7:4];
  assign wdata0 = wdata << sh0;
  assign wdata1 = wdata >> sh1;
  assign merged = 32'({(split ? beat1 : 32'h0), beat0} >> sh0);

  always_comb begin
    rdata = merged;
    case (access_size)
      MEM_ACCESS_BYTE: rdata = load_unsigned ? {24'h0, merged[7:0]}
                                             : {{24{merged[7]}}, merged[7:0]};
      MEM_ACCESS_HALF: rdata = load_unsigned ? {16'h0, merged[15:0]}
                                             : {{16{merged[15]}}, merged[15:0]};
      default:         rdata = merged;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access, issues one or two word-aligned bus
// beats, merges load data and returns a single-cycle completion pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter bit MISALIGN_SUPPORT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  mem_params_t req_params,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, nxt;
  logic [31:0] addr_q, wdata_q, beat0_q, beat1_q;
  mem_params_t params_q;
  logic        split_q, fault_q, mis_q;
  logic        accept, split_d, bad_op_d, mis_d, is_load, is_store;
  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1, load_data;

  assign accept   = req_valid && (state == IDLE);
  assign split_d  = ({1'b0, req_addr[1:0]} + size_bytes(req_params.access_size)) > 3'd4;
  assign bad_op_d = (req_params.op != MEM_OP_READ) && (req_params.op != MEM_OP_WRITE);
  assign mis_d    = split_d && !MISALIGN_SUPPORT && !bad_op_d;
  assign is_load  = params_q.op == MEM_OP_READ;
  assign is_store = params_q.op == MEM_OP_WRITE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      params_q <= '0;
      split_q  <= 1'b0;
      fault_q  <= 1'b0;
      mis_q    <= 1'b0;
      beat0_q  <= '0;
      beat1_q  <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        params_q <= req_params;
        split_q  <= split_d;
        fault_q  <= bad_op_d || mis_d;
        mis_q    <= mis_d;
        beat0_q  <= '0;
        beat1_q  <= '0;
      end
      if (state == WAIT0 && mem_rvalid) beat0_q <= mem_rdata;
      if (state == WAIT1 && mem_rvalid) beat1_q <= mem_rdata;
    end
  end

  load_store_unit_align u_align (
    .off          (addr_q[1:0]),
    .access_size  (params_q.access_size),
    .load_unsigned(params_q.load_unsigned),
    .split        (split_q),
    .wdata        (wdata_q),
    .beat0        (beat0_q),
    .beat1        (beat1_q),
    .be0          (be0),
    .be1          (be1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .rdata        (load_data)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (req_valid) nxt = (bad_op_d || mis_d) ? RESP : REQ0;
      REQ0:  if (mem_gnt) nxt = is_load ? WAIT0 : (split_q ? REQ1 : RESP);
      WAIT0: if (mem_rvalid) nxt = split_q ? REQ1 : RESP;
      REQ1:  if (mem_gnt) nxt = is_load ? WAIT1 : RESP;
      WAIT1: if (mem_rvalid) nxt = RESP;
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Bus and response outputs decode from registered state only, so they move
  // on clock edges and hold steady while a beat waits for its grant.
  always_comb begin
    req_ready       = (state == IDLE);
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_misaligned = 1'b0;
    mem_req         = 1'b0;
    mem_addr        = '0;
    mem_we          = 1'b0;
    mem_be          = '0;
    mem_wdata       = '0;
    case (state)
      REQ0: begin
        mem_req   = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_we    = is_store;
        mem_be    = be0;
        mem_wdata = wdata0;
      end
      REQ1: begin
        mem_req   = 1'b1;
        mem_addr  = {addr_q[31:2] + 30'd1, 2'b00};
        mem_we    = is_store;
        mem_be    = be1;
        mem_wdata = wdata1;
      end
      RESP: begin
        resp_valid      = 1'b1;
        resp_misaligned = mis_q;
        resp_rdata      = (is_load && !fault_q) ? load_data : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: zero-wait bus responder, one DUT with
// split support and one without.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  mem_params_t req_params;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        nm_req_valid, nm_req_ready, nm_resp_valid, nm_resp_misaligned;
  logic [31:0] nm_resp_rdata, nm_mem_addr, nm_mem_wdata;
  logic        nm_mem_req, nm_mem_we, nm_bus_seen;
  logic [3:0]  nm_mem_be;
  logic        tie0 = 1'b0;
  logic [31:0] tie0_32 = 32'h0;

  logic [31:0] log_addr [0:63];
  logic [31:0] log_wd   [0:63];
  logic [3:0]  log_be   [0:63];
  logic        log_we   [0:63];
  logic [31:0] rd_tab   [0:31];
  logic [5:0]  n_beats;
  logic [4:0]  rd_idx;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  load_store_unit #(.MISALIGN_SUPPORT(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_params(req_params),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.MISALIGN_SUPPORT(1'b0)) dut_nm (
    .clock(clock), .reset(reset),
    .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_params(req_params),
    .resp_valid(nm_resp_valid), .resp_rdata(nm_resp_rdata), .resp_misaligned(nm_resp_misaligned),
    .mem_req(nm_mem_req), .mem_addr(nm_mem_addr), .mem_we(nm_mem_we), .mem_be(nm_mem_be),
    .mem_wdata(nm_mem_wdata), .mem_gnt(tie0), .mem_rvalid(tie0), .mem_rdata(tie0_32)
  );

  // Zero-wait bus: grant immediately, read data one cycle after the grant
  assign mem_gnt = mem_req;

  always @(posedge clock) begin
    if (reset) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      n_beats    <= '0;
      rd_idx     <= '0;
    end else begin
      mem_rvalid <= 1'b0;
      if (mem_req && mem_gnt) begin
        log_addr[n_beats] <= mem_addr;
        log_wd[n_beats]   <= mem_wdata;
        log_be[n_beats]   <= mem_be;
        log_we[n_beats]   <= mem_we;
        n_beats           <= n_beats + 6'd1;
        if (!mem_we) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= rd_tab[rd_idx];
          rd_idx     <= rd_idx + 5'd1;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (reset) nm_bus_seen <= 1'b0;
    else if (nm_mem_req || nm_mem_we || nm_mem_be != 4'h0 || nm_mem_addr != 32'h0 || nm_mem_wdata != 32'h0)
      nm_bus_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [5:0] i, input logic [31:0] a,
                          input logic [3:0] be, input logic we);
    chk({tag, "_addr"}, log_addr[i], a);
    chk({tag, "_be"}, {28'h0, log_be[i]}, {28'h0, be});
    chk({tag, "_we"}, {31'h0, log_we[i]}, {31'h0, we});
  endtask

  task automatic do_req(input string tag, input mem_op_t op, input mem_access_t sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, output logic [31:0] rd, output logic mis,
                        output logic [5:0] b0);
    int lat;
    @(negedge clock);
    b0 = n_beats;
    req_valid  = 1'b1;
    req_addr   = a;
    req_wdata  = wd;
    req_params = '{op: op, access_size: sz, load_unsigned: uns};
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = -1;
    rd  = '0;
    mis = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        lat = k;
        rd  = resp_rdata;
        mis = resp_misaligned;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(negedge clock);
    chk({tag, "_pulse"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  logic [31:0] rd;
  logic        mis;
  logic [5:0]  b0;
  int          extra;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    nm_req_valid = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_params = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_memreq", {31'h0, mem_req}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_resp", {30'h0, resp_valid, resp_misaligned}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    reset = 1'b0;

    rd_tab[rd_idx] = 32'hDEADBEEF;
    do_req("lw", MEM_OP_READ, MEM_ACCESS_WORD, 1'b0, 32'h100, 32'h0, 3, rd, mis, b0);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_nbeats", {26'h0, n_beats - b0}, 32'd1);
    chk_beat("lw", b0, 32'h100, 4'b1111, 1'b0);

    rd_tab[rd_idx] = 32'h80123456;
    do_req("lb", MEM_OP_READ, MEM_ACCESS_BYTE, 1'b0, 32'h203, 32'h0, 3, rd, mis, b0);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    chk_beat("lb", b0, 32'h200, 4'b1000, 1'b0);

    rd_tab[rd_idx] = 32'h80123456;
    do_req("lbu", MEM_OP_READ, MEM_ACCESS_BYTE, 1'b1, 32'h203, 32'h0, 3, rd, mis, b0);
    chk("lbu_rdata", rd, 32'h00000080);

    rd_tab[rd_idx] = 32'h11ABCD22;
    do_req("lh", MEM_OP_READ, MEM_ACCESS_HALF, 1'b0, 32'h101, 32'h0, 3, rd, mis, b0);
    chk("lh_rdata", rd, 32'hFFFFABCD);
    chk_beat("lh", b0, 32'h100, 4'b0110, 1'b0);

    do_req("sh", MEM_OP_WRITE, MEM_ACCESS_HALF, 1'b0, 32'h106, 32'h1234, 2, rd, mis, b0);
    chk("sh_rdata", rd, 32'h0);
    chk("sh_nbeats", {26'h0, n_beats - b0}, 32'd1);
    chk_beat("sh", b0, 32'h104, 4'b1100, 1'b1);
    chk("sh_wd", log_wd[b0], 32'h12340000);

    rd_tab[rd_idx]        = 32'hAABBCCDD;
    rd_tab[rd_idx + 5'd1] = 32'h11223344;
    do_req("lw_split", MEM_OP_READ, MEM_ACCESS_WORD, 1'b0, 32'h0FFFFFFE, 32'h0, 5, rd, mis, b0);
    chk("lw_split_rdata", rd, 32'h3344AABB);
    chk_beat("lw_split0", b0, 32'h0FFFFFFC, 4'b1100, 1'b0);
    chk_beat("lw_split1", b0 + 6'd1, 32'h10000000, 4'b0011, 1'b0);

    do_req("sw_wrap", MEM_OP_WRITE, MEM_ACCESS_WORD, 1'b0, 32'hFFFFFFFF, 32'h44332211, 3, rd, mis, b0);
    chk("sw_wrap_nbeats", {26'h0, n_beats - b0}, 32'd2);
    chk_beat("sw_wrap0", b0, 32'hFFFFFFFC, 4'b1000, 1'b1);
    chk("sw_wrap0_wd", log_wd[b0], 32'h11000000);
    chk_beat("sw_wrap1", b0 + 6'd1, 32'h00000000, 4'b0111, 1'b1);
    chk("sw_wrap1_wd", log_wd[b0 + 6'd1], 32'h00443322);

    do_req("badop", MEM_OP_NONE, MEM_ACCESS_WORD, 1'b0, 32'h400, 32'h0, 1, rd, mis, b0);
    chk("badop_mis", {31'h0, mis}, 32'h0);
    chk("badop_nbeats", {26'h0, n_beats - b0}, 32'd0);

    // No split support: a word-crossing halfword faults without a bus beat
    @(negedge clock);
    nm_req_valid = 1'b1;
    req_addr     = 32'h103;
    req_params   = '{op: MEM_OP_READ, access_size: MEM_ACCESS_HALF, load_unsigned: 1'b0};
    @(posedge clock);
    #1 nm_req_valid = 1'b0;
    @(negedge clock);
    chk("nm_resp", {30'h0, nm_resp_valid, nm_resp_misaligned}, 32'h3);
    chk("nm_rdata", nm_resp_rdata, 32'h0);
    @(negedge clock);
    chk("nm_pulse", {30'h0, nm_resp_valid, nm_req_ready}, 32'h1);
    chk("nm_nobus", {31'h0, nm_bus_seen}, 32'h0);

    // Reset while waiting for read data aborts the access silently
    rd_tab[rd_idx] = 32'h55555555;
    @(negedge clock);
    req_valid  = 1'b1;
    req_addr   = 32'h300;
    req_params = '{op: MEM_OP_READ, access_size: MEM_ACCESS_WORD, load_unsigned: 1'b0};
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk("abort_req0", {31'h0, mem_req}, 32'h1);
    @(negedge clock);
    chk("abort_wait0", {30'h0, mem_req, req_ready}, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_idle", {29'h0, resp_valid, req_ready, mem_req}, 32'h2);
    extra = 0;
    repeat (4) begin
      @(negedge clock);
      if (resp_valid) extra++;
    end
    chk("abort_noresp", 32'(extra), 32'h0);

    rd_tab[rd_idx] = 32'h0000FF00;
    do_req("post_rst", MEM_OP_READ, MEM_ACCESS_BYTE, 1'b1, 32'h001, 32'h0, 3, rd, mis, b0);
    chk("post_rst_rdata", rd, 32'h000000FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
